// File: rtl/uart_auth_rx_if.sv
// Signal bundle between the RX pin / rider sensing and the Segway enable logic.
// Handshake: rx_rdy is a valid-only, one-clk pulse qualifying rx_data and cmd_err;
// there is no ready, because a UART byte cannot be back-pressured and the consumer
// must take it in the cycle it is presented. frm_err is an independent one-clk pulse.
interface uart_auth_rx_if;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       cmd_err;
  logic       rx_state_dbg;
  logic [1:0] auth_state_dbg;

  modport master (
    output RX, rider_off,
    input  pwr_up, rx_data, rx_rdy, frm_err, cmd_err, rx_state_dbg, auth_state_dbg
  );

  modport slave (
    input  RX, rider_off,
    output pwr_up, rx_data, rx_rdy, frm_err, cmd_err, rx_state_dbg, auth_state_dbg
  );
endinterface

// File: rtl/uart_auth_rx.sv
// 8N1 UART receiver feeding the rider command authorization FSM.
// 'G' powers the drive up; 'S' powers it down (immediately if the rider is off,
// otherwise it waits in PWR2 until the rider steps off or a new 'G' arrives).
module uart_auth_rx #(
  parameter int         BAUD_DIV = 5208,
  parameter logic [7:0] CMD_GO   = 8'h47,
  parameter logic [7:0] CMD_STOP = 8'h53
) (
  input logic            clk,
  input logic            rst_n,
  uart_auth_rx_if.slave  bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

  typedef enum logic [0:0] {IDLE, RECV} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  rx_state_t   rx_state, rx_next;
  auth_state_t auth_state, auth_next;

  logic          s1, s2, s3;
  logic          fall;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rx_data;
  logic          rx_rdy, frm_err, cmd_err, pwr_up;
  logic          start, tick, done_ok, done_bad;

  // Two-flop synchronizer plus a third flop for edge detect; preset high so reset release is not a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus.RX;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

  // Receive FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  // Receive FSM next state and sample strobes; a falling edge during RECV is ignored.
  always_comb begin
    rx_next  = rx_state;
    start    = 1'b0;
    tick     = 1'b0;
    done_ok  = 1'b0;
    done_bad = 1'b0;
    case (rx_state)
      IDLE: begin
        if (fall) begin
          start   = 1'b1;
          rx_next = RECV;
        end
      end
      RECV: begin
        if (baud_cnt == '0) begin
          tick = 1'b1;
          if (bit_cnt == 4'd0 && s2) begin
            rx_next = IDLE;              // start bit read high: glitch
          end else if (bit_cnt == 4'd9) begin
            rx_next  = IDLE;
            done_ok  = s2;
            done_bad = ~s2;
          end
        end
      end
      default: rx_next = IDLE;
    endcase
  end

  // Bit timing, shift register and the received-byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      rx_data  <= 8'h00;
      rx_rdy   <= 1'b0;
      frm_err  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      rx_rdy  <= done_ok;
      frm_err <= done_bad;
      cmd_err <= done_ok && (shreg != CMD_GO) && (shreg != CMD_STOP);
      if (done_ok) rx_data <= shreg;
      if (start) begin
        baud_cnt <= HALF_BIT;
        bit_cnt  <= 4'd0;
      end else if (tick) begin
        baud_cnt <= FULL_BIT;
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) shreg <= {s2, shreg[7:1]};
      end else if (rx_state == RECV) begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  // Auth FSM state register; pwr_up registered alongside so it tracks the state with no extra delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_state <= OFF;
      pwr_up     <= 1'b0;
    end else begin
      auth_state <= auth_next;
      pwr_up     <= (auth_next != OFF);
    end
  end

  // Auth FSM next state: moves only on rx_rdy, except the rider-off exit from PWR2 which wins every clk.
  always_comb begin
    auth_next = auth_state;
    case (auth_state)
      OFF: begin
        if (rx_rdy && rx_data == CMD_GO) auth_next = PWR1;
      end
      PWR1: begin
        if (rx_rdy && rx_data == CMD_STOP) auth_next = bus.rider_off ? OFF : PWR2;
      end
      PWR2: begin
        if (bus.rider_off)                    auth_next = OFF;
        else if (rx_rdy && rx_data == CMD_GO) auth_next = PWR1;
      end
      default: auth_next = OFF;
    endcase
  end

  assign bus.pwr_up         = pwr_up;
  assign bus.rx_data        = rx_data;
  assign bus.rx_rdy         = rx_rdy;
  assign bus.frm_err        = frm_err;
  assign bus.cmd_err        = cmd_err;
  assign bus.rx_state_dbg   = rx_state;
  assign bus.auth_state_dbg = auth_state;

endmodule

// File: tb/tb_uart_auth_rx.sv
// Bench for uart_auth_rx at BAUD_DIV=32: command bytes, rider-off exit,
// framing errors, glitches, back-to-back bytes and mid-byte reset.
module tb_uart_auth_rx;

  localparam int BAUD = 32;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   rdy_cnt = 0;
  int   frm_cnt = 0;

  // Scoreboard entry: {expected cmd_err, expected rx_data}
  logic [8:0] exp_q[$];

  uart_auth_rx_if bus();

  uart_auth_rx #(.BAUD_DIV(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every rx_rdy pops one expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frm_err) frm_cnt++;
      if (bus.rx_rdy) begin
        logic [8:0] e;
        rdy_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: rx_rdy with data %02h, expected no byte", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rx_data !== e[7:0]) begin
            errors++;
            $display("FAIL sb_data: got %02h expected %02h", bus.rx_data, e[7:0]);
          end
          checks++;
          if (bus.cmd_err !== e[8]) begin
            errors++;
            $display("FAIL sb_cmd_err: got %b expected %b (data %02h)", bus.cmd_err, e[8], e[7:0]);
          end
        end
      end
    end
  end

  // Driver tasks: all start and end on a negedge
  task automatic send_bit(input logic b);
    bus.RX = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    bus.RX = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.RX = 1'b1;
    bus.rider_off = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL rst_pwr_up: got %b expected 0", bus.pwr_up); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %02h expected 00", bus.rx_data); end
    checks++; if (bus.rx_rdy !== 1'b0) begin errors++; $display("FAIL rst_rx_rdy: got %b expected 0", bus.rx_rdy); end
    checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL rst_frm_err: got %b expected 0", bus.frm_err); end
    checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL rst_cmd_err: got %b expected 0", bus.cmd_err); end
    checks++; if (bus.rx_state_dbg !== 1'b0) begin errors++; $display("FAIL rst_rx_state: got %b expected 0", bus.rx_state_dbg); end
    checks++; if (bus.auth_state_dbg !== 2'd0) begin errors++; $display("FAIL rst_auth_state: got %0d expected 0", bus.auth_state_dbg); end
    rst_n = 1'b1;
    idle(BAUD);
    checks++; if (rdy_cnt !== 0 || bus.rx_state_dbg !== 1'b0) begin errors++; $display("FAIL rst_release: rdy=%0d state=%b expected 0/0", rdy_cnt, bus.rx_state_dbg); end
  endtask

  task automatic test_go;
    int cnt = 0;
    bit found = 0;
    int r0 = rdy_cnt;
    exp_q.push_back({1'b0, 8'h47});
    fork
      send_byte(8'h47, 1'b1);
      begin
        while (!found && cnt < 400) begin
          @(posedge clk); #1;
          cnt++;
          if (bus.rx_rdy) found = 1;
        end
        checks++;
        if (!found) begin
          errors++; $display("FAIL go_timeout: rx_rdy not seen in %0d clk", cnt);
        end else begin
          checks++;
          if (cnt - 1 < 306 || cnt - 1 > 308) begin errors++; $display("FAIL go_latency: got %0d clk expected 306..308", cnt - 1); end
          checks++;
          if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL go_pwr_early: got %b expected 0", bus.pwr_up); end
          @(posedge clk); #1;
          checks++;
          if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL go_pwr_up: got %b expected 1", bus.pwr_up); end
        end
      end
    join
    idle(BAUD);
    checks++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL go_rdy_count: got %0d expected 1", rdy_cnt - r0); end
  endtask

  task automatic test_stop_rider_on;
    exp_q.push_back({1'b0, 8'h53});
    bus.rider_off = 1'b0;
    send_byte(8'h53, 1'b1);
    idle(BAUD);
    checks++; if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL stop_on_pwr: got %b expected 1", bus.pwr_up); end
    checks++; if (bus.auth_state_dbg !== 2'd2) begin errors++; $display("FAIL stop_on_state: got %0d expected 2", bus.auth_state_dbg); end
    idle(500);
    bus.rider_off = 1'b1;
    #1;
    checks++; if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL rider_off_early: got %b expected 1", bus.pwr_up); end
    @(posedge clk); #1;
    checks++; if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL rider_off_pwr: got %b expected 0", bus.pwr_up); end
    @(negedge clk);
    bus.rider_off = 1'b0;
  endtask

  task automatic test_stop_rider_off;
    int cnt = 0;
    bit found = 0;
    exp_q.push_back({1'b0, 8'h47});
    send_byte(8'h47, 1'b1);
    idle(BAUD);
    checks++; if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL off_setup_pwr: got %b expected 1", bus.pwr_up); end
    bus.rider_off = 1'b1;
    exp_q.push_back({1'b0, 8'h53});
    fork
      send_byte(8'h53, 1'b1);
      begin
        while (!found && cnt < 400) begin
          @(posedge clk); #1;
          cnt++;
          if (bus.rx_rdy) found = 1;
        end
        checks++;
        if (!found) begin
          errors++; $display("FAIL off_timeout: rx_rdy not seen in %0d clk", cnt);
        end else begin
          checks++;
          if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL off_pwr_early: got %b expected 1", bus.pwr_up); end
          @(posedge clk); #1;
          checks++;
          if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL off_pwr_fall: got %b expected 0", bus.pwr_up); end
        end
      end
    join
    idle(BAUD);
    exp_q.push_back({1'b1, 8'h41});
    send_byte(8'h41, 1'b1);
    idle(BAUD);
    checks++; if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL bad_cmd_pwr: got %b expected 0", bus.pwr_up); end
    bus.rider_off = 1'b0;
  endtask

  task automatic test_frame_err;
    int r0 = rdy_cnt;
    int f0 = frm_cnt;
    send_byte(8'h47, 1'b0);
    idle(2 * BAUD);
    checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL frm_count: got %0d expected 1", frm_cnt - f0); end
    checks++; if (rdy_cnt !== r0) begin errors++; $display("FAIL frm_rdy: got %0d pulses expected 0", rdy_cnt - r0); end
    checks++; if (bus.rx_data !== 8'h41) begin errors++; $display("FAIL frm_data_hold: got %02h expected 41", bus.rx_data); end
    checks++; if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL frm_pwr: got %b expected 0", bus.pwr_up); end
    exp_q.push_back({1'b0, 8'h47});
    send_byte(8'h47, 1'b1);
    idle(BAUD);
    checks++; if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL frm_recover_pwr: got %b expected 1", bus.pwr_up); end
  endtask

  task automatic test_back_to_back;
    int r0 = rdy_cnt;
    int f0 = frm_cnt;
    bus.RX = 1'b0;
    repeat (10) @(negedge clk);
    bus.RX = 1'b1;
    idle(2 * BAUD);
    checks++; if (rdy_cnt !== r0 || frm_cnt !== f0) begin errors++; $display("FAIL glitch_out: rdy=%0d frm=%0d expected 0/0", rdy_cnt - r0, frm_cnt - f0); end
    checks++; if (bus.rx_state_dbg !== 1'b0) begin errors++; $display("FAIL glitch_state: got %b expected 0", bus.rx_state_dbg); end
    exp_q.push_back({1'b0, 8'h47});
    exp_q.push_back({1'b0, 8'h53});
    send_byte(8'h47, 1'b1);
    send_byte(8'h53, 1'b1);
    idle(BAUD);
    checks++; if (rdy_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", rdy_cnt - r0); end
    checks++; if (bus.auth_state_dbg !== 2'd2) begin errors++; $display("FAIL b2b_state: got %0d expected 2", bus.auth_state_dbg); end
  endtask

  task automatic test_mid_reset;
    int r0;
    checks++; if (bus.pwr_up !== 1'b1) begin errors++; $display("FAIL mrst_setup: got %b expected 1", bus.pwr_up); end
    r0 = rdy_cnt;
    fork
      send_byte(8'h47, 1'b1);
      begin
        repeat (4 * BAUD + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pwr_up !== 1'b0) begin errors++; $display("FAIL mrst_pwr: got %b expected 0", bus.pwr_up); end
        checks++;
        if (bus.rx_state_dbg !== 1'b0 || bus.rx_rdy !== 1'b0) begin errors++; $display("FAIL mrst_rx: state=%b rdy=%b expected 0/0", bus.rx_state_dbg, bus.rx_rdy); end
      end
    join
    idle(4);
    rst_n = 1'b1;
    idle(1000);
    checks++; if (rdy_cnt !== r0) begin errors++; $display("FAIL mrst_rdy: got %0d pulses expected 0", rdy_cnt - r0); end
    checks++; if (bus.pwr_up !== 1'b0 || bus.auth_state_dbg !== 2'd0) begin errors++; $display("FAIL mrst_idle: pwr=%b state=%0d expected 0/0", bus.pwr_up, bus.auth_state_dbg); end
    checks++; if (bus.rx_state_dbg !== 1'b0) begin errors++; $display("FAIL mrst_rx_idle: got %b expected 0", bus.rx_state_dbg); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_go();
    test_stop_rider_on();
    test_stop_rider_off();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d bytes never received, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_auth_rx.md
Name: uart_auth_rx

Overview:
UART receiver (8N1, LSB first) combined with the command authorization FSM.
It decodes 'G' (0x47) and 'S' (0x53) command bytes arriving from the rider's remote and drives pwr_up, which enables the balance controller and the motor drive.
It sits in the Segway top level between the RX pin and the balance/steer enable logic.
It is the receiving end of the bench's UART command sender.

Parameters:
BAUD_DIV, 5208, clocks per bit (50 MHz / 9600 baud); must be ≥ 8.
CMD_GO, 8'h47, byte that authorizes power-up.
CMD_STOP, 8'h53, byte that requests power-down.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial input; asynchronous to clk; idles high
rider_off  input  1  high when the load cells report no rider (sum below threshold)
pwr_up  output  1  power/drive enable; registered
rx_data  output  8  last correctly framed byte; holds until the next good byte
rx_rdy  output  1  one-cycle pulse when rx_data updates
frm_err  output  1  one-cycle pulse when the stop bit samples as 0; the byte is discarded
cmd_err  output  1  one-cycle pulse concurrent with rx_rdy when the byte is neither CMD_GO nor CMD_STOP

Behaviour:
Reset values:
- pwr_up=0, rx_data=0, rx_rdy=0, frm_err=0, cmd_err=0.
- Both synchronizer flops preset to 1, so there is no false start on reset release.
- Receive FSM = IDLE; auth FSM = OFF.

RX path:
- RX passes through a 2-flop synchronizer, then a third flop for falling-edge detect.

Receive FSM, states IDLE and RECV:
- IDLE: on a synced falling edge, load baud_cnt = BAUD_DIV/2 (truncating), bit_cnt = 0, and go to RECV.
- RECV: baud_cnt decrements each clk. At baud_cnt==0, sample the synced RX, reload BAUD_DIV-1, and increment bit_cnt.
- Sample 0 (start bit) reading 1: glitch, return to IDLE with no outputs.
- Samples 1-8: shifted into the data register LSB first.
- Sample 9 (stop bit):
  - If 1: rx_data is loaded and rx_rdy pulses on the next clk.
  - If 0: frm_err pulses instead, and rx_data is unchanged.
  - Either way, return to IDLE on the same edge.
- Latency: rx_rdy rises 9.5 bit times (±1 clk) plus 3 clk after the RX falling edge.
- A falling edge seen during RECV is ignored.
- A new start bit is accepted the first clk after returning to IDLE, so back-to-back bytes with one stop bit are received.

Auth FSM, states OFF, PWR1, PWR2:
- pwr_up = (state != OFF), registered.
- The FSM evaluates only when rx_rdy is high, except for the PWR2 rider_off exit.
- OFF:
  - rx_rdy & CMD_GO → PWR1.
  - CMD_STOP and other bytes → stay.
- PWR1:
  - rx_rdy & CMD_STOP & rider_off → OFF.
  - rx_rdy & CMD_STOP & !rider_off → PWR2.
  - CMD_GO → stay.
- PWR2:
  - rider_off → OFF. This is evaluated every clk, and has priority over a simultaneous rx_rdy.
  - rx_rdy & CMD_GO & !rider_off → PWR1.
- Timing: pwr_up changes on the clk edge that ends the rx_rdy cycle, i.e. one clk after rx_rdy is seen high.
- Rider stepping off in PWR2: pwr_up falls one clk after rider_off rises.

Error and reset handling:
- frm_err bytes never affect the auth FSM.
- cmd_err bytes leave the auth state unchanged.
- Reset asserted mid-byte or while powered: everything returns to reset values immediately (asynchronously).
- After reset, pwr_up stays 0 until a new CMD_GO is received.

Test Plan:
1. BAUD_DIV=32. Reset, then send 0x47 8N1 → rx_rdy pulses once, rx_data=8'h47, cmd_err=0, pwr_up rises 1 clk after rx_rdy. Check rx_rdy occurs 304±1 + 3 clk after the start edge.
2. pwr_up=1, rider_off=0, send 0x53 → pwr_up stays 1 (PWR2). Raise rider_off 500 clk later → pwr_up=0 exactly 1 clk later.
3. pwr_up=1, rider_off=1, send 0x53 → pwr_up falls 1 clk after rx_rdy. Then send 0x41 → rx_rdy and cmd_err pulse together, pwr_up stays 0.
4. Send 0x47 with the stop bit forced to 0 → frm_err pulses once, rx_rdy never pulses, rx_data keeps its prior value, pwr_up stays 0. Then send a good 0x47 → pwr_up=1.
5. Drive a RX low glitch of 10 clk (< half bit) → no rx_rdy and no frm_err, FSM back in IDLE. Then send 0x47 and 0x53 back-to-back with one stop bit → two rx_rdy pulses, data 8'h47 then 8'h53.
6. Assert rst_n=0 midway through the data bits of 0x47 while pwr_up=1 → pwr_up=0 immediately, no rx_rdy. After release, a stuck-high RX produces no activity for 1000 clk.
